// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file: default sizing, address width helper,
// instruction field positions for Ra/Rb/Rc and the hard-wired zero register index.
package regfile_sb_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NREGS    = 16;
  localparam int DEF_NRD      = 2;
  localparam int DEF_MAX_PEND = 4;

  localparam int ZERO_REG = 0;

  // Register fields in the instruction word, consumed by the select/encode logic.
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int IR_R_W    = 4;

  // Width of a register index; never zero, even for a one-entry file.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks registers whose results are in flight, counts them,
// and decides whether a new reservation can be accepted this cycle.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int AW       = addr_w(DEF_NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ready,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      pend_cnt
);

  localparam int NSLOT = 1 << AW;
  localparam logic [AW:0] MAX_P = (AW+1)'(MAX_PEND);

  logic [NREGS-1:0] busy_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_nxt;
  logic [NSLOT-1:0] valid_mask;
  logic [NSLOT-1:0] busy_ext;
  logic [NSLOT-1:0] busy_nxt;
  logic             wr_hit;
  logic             retire;
  logic             same_slot;
  logic             accept;
  cnt_op_e          cnt_op;

  // Widen to the full address space so any index is safe; slots past NREGS stay 0.
  always_comb begin
    valid_mask = '0;
    busy_ext   = '0;
    for (int i = 0; i < NREGS; i++) begin
      valid_mask[i] = 1'b1;
      busy_ext[i]   = busy_q[i];
    end
  end

  assign wr_hit    = wr_en & valid_mask[wr_addr];
  assign retire    = wr_hit & busy_ext[wr_addr];
  assign same_slot = wr_hit && (wr_addr == rsv_addr) && busy_ext[rsv_addr];
  assign rsv_ready = ((cnt_q < MAX_P) && !busy_ext[rsv_addr] && valid_mask[rsv_addr])
                     || same_slot;
  assign accept    = rsv_valid & rsv_ready;

  always_comb begin
    busy_nxt = busy_ext;
    if (wr_hit) busy_nxt[wr_addr] = 1'b0;
    if (accept) busy_nxt[rsv_addr] = 1'b1;

    // A retire and an accept in the same cycle cancel, whichever addresses they hit.
    cnt_op = CNT_HOLD;
    if (accept && !retire)      cnt_op = CNT_INC;
    else if (retire && !accept) cnt_op = CNT_DEC;

    case (cnt_op)
      CNT_INC: cnt_nxt = cnt_q + (AW+1)'(1);
      CNT_DEC: cnt_nxt = cnt_q - (AW+1)'(1);
      default: cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt[NREGS-1:0];
      cnt_q  <= cnt_nxt;
    end
  end

  assign busy_vec = busy_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with NRD combinational read ports and a busy scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write-through from the write port to matching reads.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int MAX_PEND = DEF_MAX_PEND,
  localparam int AW      = addr_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD-1:0]       rd_base,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  output logic [NREGS-1:0]     busy_vec,
  output logic [AW:0]          pend_cnt
);

  logic [WIDTH-1:0] regs [NREGS];

  regfile_sb_scoreboard #(
    .NREGS    (NREGS),
    .MAX_PEND (MAX_PEND),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy_vec  (busy_vec),
    .pend_cnt  (pend_cnt)
  );

  // Register 0 is stored like any other; only base-mode reads hide it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++)
        if (wr_addr == AW'(i)) regs[i] <= wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_hit;

  always_comb begin
    wr_hit = 1'b0;
    for (int j = 0; j < NREGS; j++)
      if (wr_addr == AW'(j)) wr_hit = wr_en;
  end
`endif

  // Unmatched (out-of-range) addresses fall through to the zero defaults.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int j = 0; j < NREGS; j++) begin
        if (rd_addr[p*AW +: AW] == AW'(j)) begin
          rd_data[p*WIDTH +: WIDTH] = regs[j];
          rd_busy[p]                = busy_vec[j];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == rd_addr[p*AW +: AW])) begin
        rd_data[p*WIDTH +: WIDTH] = wr_data;
        rd_busy[p]                = 1'b0;
      end
`endif
      if (rd_base[p] && (rd_addr[p*AW +: AW] == AW'(ZERO_REG))) begin
        rd_data[p*WIDTH +: WIDTH] = '0;
        rd_busy[p]                = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters: 32-bit, 16 regs, 2 ports, 4 pending).
module tb_regfile_sb;

  localparam int WIDTH    = 32;
  localparam int NREGS    = 16;
  localparam int NRD      = 2;
  localparam int MAX_PEND = 4;
  localparam int AW       = 4;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD-1:0]       rd_base;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_ready;
  logic [NREGS-1:0]     busy_vec;
  logic [AW:0]          pend_cnt;

  int tests = 0;
  int fails = 0;

  regfile_sb #(
    .WIDTH    (WIDTH),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .rd_addr   (rd_addr),
    .rd_base   (rd_base),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy_vec  (busy_vec),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    clr = 1'b1; idle(); wr_addr = '0; wr_data = '0; rsv_addr = '0;
    rd_addr = {4'd3, 4'd5}; rd_base = 2'b00;
    #12;
    tests++; if (rd_data !== 64'h0) begin fails++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    tests++; if (rd_busy !== 2'b00) begin fails++; $display("FAIL reset_rd_busy got %b exp 00", rd_busy); end
    tests++; if (busy_vec !== 16'h0) begin fails++; $display("FAIL reset_busy_vec got %h exp 0", busy_vec); end
    tests++; if (pend_cnt !== 5'd0) begin fails++; $display("FAIL reset_pend got %0d exp 0", pend_cnt); end
    @(negedge clk); clr = 1'b0;
    tick();
  endtask

  task automatic test_clear_midrun();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    rsv_valid = 1'b1; rsv_addr = 4'd3;
    #1;
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL clr_rsv_ready got %b exp 1", rsv_ready); end
    tick(); idle();
    rd_addr = {4'd3, 4'd5}; #1;
    tests++; if (rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL clr_pre_r5 got %h exp deadbeef", rd_data[31:0]); end
    tests++; if (busy_vec !== 16'h0008 || pend_cnt !== 5'd1) begin fails++; $display("FAIL clr_pre_busy got %h/%0d exp 0008/1", busy_vec, pend_cnt); end
    tests++; if (rd_busy !== 2'b10) begin fails++; $display("FAIL clr_pre_rd_busy got %b exp 10", rd_busy); end
    #1 clr = 1'b1; #1;
    tests++; if (rd_data[31:0] !== 32'h0) begin fails++; $display("FAIL clr_r5 got %h exp 0", rd_data[31:0]); end
    tests++; if (busy_vec !== 16'h0 || pend_cnt !== 5'd0 || rd_busy !== 2'b00) begin
      fails++; $display("FAIL clr_busy got %h/%0d/%b exp 0/0/00", busy_vec, pend_cnt, rd_busy); end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_base_mode();
    do_write(4'd0, 32'h1234);
    rd_addr = {4'd0, 4'd0}; rd_base = 2'b01; #1;
    tests++; if (rd_data[31:0] !== 32'h0) begin fails++; $display("FAIL base_port0 got %h exp 0", rd_data[31:0]); end
    tests++; if (rd_data[63:32] !== 32'h1234) begin fails++; $display("FAIL base_port1 got %h exp 1234", rd_data[63:32]); end
    rsv_valid = 1'b1; rsv_addr = 4'd0; #1;
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL base_rsv_ready got %b exp 1", rsv_ready); end
    tick(); idle(); #1;
    tests++; if (rd_busy !== 2'b10 || pend_cnt !== 5'd1) begin fails++; $display("FAIL base_rd_busy got %b/%0d exp 10/1", rd_busy, pend_cnt); end
    do_write(4'd0, 32'h1234); #1;
    tests++; if (pend_cnt !== 5'd0 || busy_vec !== 16'h0) begin fails++; $display("FAIL base_retire got %0d/%h exp 0/0", pend_cnt, busy_vec); end
    rd_base = 2'b00;
  endtask

  task automatic test_pend_limit();
    for (int r = 1; r <= 4; r++) begin
      rsv_valid = 1'b1; rsv_addr = AW'(r); #1;
      tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL limit_rsv_r%0d got %b exp 1", r, rsv_ready); end
      tick();
    end
    idle(); #1;
    tests++; if (pend_cnt !== 5'd4 || busy_vec !== 16'h001E) begin fails++; $display("FAIL limit_full got %0d/%h exp 4/001e", pend_cnt, busy_vec); end
    rsv_valid = 1'b1; rsv_addr = 4'd6; #1;
    tests++; if (rsv_ready !== 1'b0) begin fails++; $display("FAIL limit_r6_block got %b exp 0", rsv_ready); end
    tick(); idle(); #1;
    tests++; if (pend_cnt !== 5'd4 || busy_vec !== 16'h001E) begin fails++; $display("FAIL limit_hold got %0d/%h exp 4/001e", pend_cnt, busy_vec); end
    do_write(4'd2, 32'h22); #1;
    tests++; if (pend_cnt !== 5'd3 || busy_vec !== 16'h001A) begin fails++; $display("FAIL limit_retire got %0d/%h exp 3/001a", pend_cnt, busy_vec); end
    rsv_valid = 1'b1; rsv_addr = 4'd6; #1;
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL limit_r6_accept got %b exp 1", rsv_ready); end
    tick(); idle();
    rd_addr = {4'd6, 4'd3}; #1;
    tests++; if (pend_cnt !== 5'd4 || busy_vec !== 16'h005A) begin fails++; $display("FAIL limit_r6_busy got %0d/%h exp 4/005a", pend_cnt, busy_vec); end
    tests++; if (rd_busy !== 2'b11) begin fails++; $display("FAIL limit_rd_busy got %b exp 11", rd_busy); end
    do_write(4'd1, 32'h11);
  endtask

  task automatic test_same_cycle();
    rsv_valid = 1'b1; rsv_addr = 4'd7;
    tick(); idle(); #1;
    tests++; if (pend_cnt !== 5'd4 || busy_vec !== 16'h00D8) begin fails++; $display("FAIL same_pre got %0d/%h exp 4/00d8", pend_cnt, busy_vec); end
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h55;
    rsv_valid = 1'b1; rsv_addr = 4'd7; #1;
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL same_rsv_ready got %b exp 1", rsv_ready); end
    tick(); idle();
    rd_addr = {4'd0, 4'd7}; #1;
    tests++; if (pend_cnt !== 5'd4 || busy_vec !== 16'h00D8) begin fails++; $display("FAIL same_busy got %0d/%h exp 4/00d8", pend_cnt, busy_vec); end
    tests++; if (rd_data[31:0] !== 32'h55) begin fails++; $display("FAIL same_r7 got %h exp 55", rd_data[31:0]); end
  endtask

  task automatic test_busy_reject();
    do_write(4'd3, 32'h33);
    rsv_valid = 1'b1; rsv_addr = 4'd8;
    tick(); idle();
    do_write(4'd4, 32'h44); #1;
    tests++; if (pend_cnt !== 5'd3 || busy_vec !== 16'h01C0) begin fails++; $display("FAIL reject_pre got %0d/%h exp 3/01c0", pend_cnt, busy_vec); end
    rsv_valid = 1'b1; rsv_addr = 4'd8; #1;
    tests++; if (rsv_ready !== 1'b0) begin fails++; $display("FAIL reject_r8_ready got %b exp 0", rsv_ready); end
    tick(); idle(); #1;
    tests++; if (pend_cnt !== 5'd3 || busy_vec !== 16'h01C0) begin fails++; $display("FAIL reject_r8_hold got %0d/%h exp 3/01c0", pend_cnt, busy_vec); end
    do_write(4'd10, 32'h10); #1;
    tests++; if (pend_cnt !== 5'd3 || busy_vec !== 16'h01C0) begin fails++; $display("FAIL reject_r10_write got %0d/%h exp 3/01c0", pend_cnt, busy_vec); end
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h66;
    rsv_valid = 1'b1; rsv_addr = 4'd11; #1;
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL diff_rsv_ready got %b exp 1", rsv_ready); end
    tick(); idle(); #1;
    tests++; if (pend_cnt !== 5'd3 || busy_vec !== 16'h0980) begin fails++; $display("FAIL diff_busy got %0d/%h exp 3/0980", pend_cnt, busy_vec); end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] exp_pre;
    logic             exp_busy;
`ifdef REGFILE_BYPASS_EN
    exp_pre  = 32'hA5A5A5A5;
    exp_busy = 1'b0;
`else
    exp_pre  = 32'h11111111;
    exp_busy = 1'b1;
`endif
    do_write(4'd9, 32'h11111111);
    rd_addr = {4'd9, 4'd9}; rd_base = 2'b00;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hA5A5A5A5; #1;
    tests++; if (rd_data[31:0] !== exp_pre) begin fails++; $display("FAIL bypass_same got %h exp %h", rd_data[31:0], exp_pre); end
    tick(); idle(); #1;
    tests++; if (rd_data[63:32] !== 32'hA5A5A5A5) begin fails++; $display("FAIL bypass_next got %h exp a5a5a5a5", rd_data[63:32]); end
    rd_addr = {4'd7, 4'd9};
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77; #1;
    tests++; if (rd_busy[1] !== exp_busy) begin fails++; $display("FAIL bypass_busy got %b exp %b", rd_busy[1], exp_busy); end
    tick(); idle(); #1;
    tests++; if (pend_cnt !== 5'd2 || busy_vec !== 16'h0900 || rd_data[63:32] !== 32'h77) begin
      fails++; $display("FAIL bypass_retire got %0d/%h/%h exp 2/0900/77", pend_cnt, busy_vec, rd_data[63:32]); end
  endtask

  initial begin
    test_reset();
    test_clear_midrun();
    test_base_mode();
    test_pend_limit();
    test_same_cycle();
    test_busy_reject();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
